// File: rtl/counter_ctrl.sv
// Command sequencer for the shared up/down counter: accepts LOAD / STEP / RUN_TO_LIMIT
// commands over valid/ready and reports completion with a one-cycle done pulse.
module counter_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  input  logic             abort,
  output logic             busy,
  output logic             load_n,
  output logic [WIDTH-1:0] data_load,
  output logic             up_down,
  output logic             ce,
  input  logic [WIDTH-1:0] count_out,
  input  logic             zero_flag,
  input  logic             max_count,
  output logic             done,
  output logic [WIDTH-1:0] resp_count,
  output logic             resp_abort
);

  localparam logic [1:0] OP_LOAD      = 2'b00;
  localparam logic [1:0] OP_STEP_UP   = 2'b01;
  localparam logic [1:0] OP_STEP_DOWN = 2'b10;
  localparam logic [1:0] OP_RUN       = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STEP,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_rem;
  logic             r_cmd_ready;
  logic             r_busy;
  logic             r_load_n;
  logic [WIDTH-1:0] r_data_load;
  logic             r_up_down;
  logic             r_done;
  logic [WIDTH-1:0] r_resp_count;
  logic             r_resp_abort;
  logic             r_aborted;
  logic             w_accept;
  logic             w_limit;
  logic             w_ce;
  logic             w_abort_exit;

  assign w_accept = cmd_valid && r_cmd_ready;
  // The limit flag is chosen by the latched run direction
  assign w_limit  = r_up_down ? max_count : zero_flag;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and combinational count enable
  always_comb begin
    w_next_state = r_state;
    w_ce         = 1'b0;
    w_abort_exit = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          unique case (cmd_op)
            OP_LOAD:                 w_next_state = S_LOAD;
            OP_STEP_UP, OP_STEP_DOWN: w_next_state = (cmd_arg != '0) ? S_STEP : S_DONE;
            OP_RUN:                  w_next_state = S_RUN;
            default:                 w_next_state = S_IDLE;
          endcase
        end
      end
      S_LOAD: w_next_state = S_DONE;
      S_STEP: begin
        if (abort) begin
          w_next_state = S_DONE;
          w_abort_exit = 1'b1;
        end else begin
          w_ce = 1'b1;
          if (r_rem == WIDTH'(1)) begin
            w_next_state = S_DONE;
          end
        end
      end
      S_RUN: begin
        // Reaching the limit wins over a simultaneous abort
        if (w_limit) begin
          w_next_state = S_DONE;
        end else if (abort) begin
          w_next_state = S_DONE;
          w_abort_exit = 1'b1;
        end else begin
          w_ce = 1'b1;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Registered outputs, command latches and step counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_ready  <= 1'b1;
      r_busy       <= 1'b0;
      r_load_n     <= 1'b1;
      r_data_load  <= '0;
      r_up_down    <= 1'b0;
      r_done       <= 1'b0;
      r_resp_count <= '0;
      r_resp_abort <= 1'b0;
      r_rem        <= '0;
      r_aborted    <= 1'b0;
    end else begin
      r_cmd_ready <= (w_next_state == S_IDLE);
      r_busy      <= (w_next_state != S_IDLE);
      r_load_n    <= (w_next_state != S_LOAD);
      r_done      <= (r_state == S_DONE);
      if (r_state == S_DONE) begin
        r_resp_count <= count_out;
        r_resp_abort <= r_aborted;
      end
      if (w_accept) begin
        r_aborted <= 1'b0;
        unique case (cmd_op)
          OP_LOAD:      r_data_load <= cmd_arg;
          OP_STEP_UP: begin
            r_up_down <= 1'b1;
            r_rem     <= cmd_arg;
          end
          OP_STEP_DOWN: begin
            r_up_down <= 1'b0;
            r_rem     <= cmd_arg;
          end
          OP_RUN:       r_up_down <= cmd_arg[0];
          default:      r_up_down <= r_up_down;
        endcase
      end else if (r_state == S_STEP) begin
        r_rem <= r_rem - WIDTH'(1);
      end
      if (w_abort_exit) begin
        r_aborted <= 1'b1;
      end
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign busy       = r_busy;
  assign load_n     = r_load_n;
  assign data_load  = r_data_load;
  assign up_down    = r_up_down;
  assign ce         = w_ce;
  assign done       = r_done;
  assign resp_count = r_resp_count;
  assign resp_abort = r_resp_abort;

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: a counter model closes the loop, and a command-level
// predictor builds the expected per-cycle trace that one compare process checks.
module tb_counter_ctrl;

  localparam int unsigned W = 4;
  localparam int MAXV = 15;
  localparam int MODV = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic [1:0]   cmd_op = 2'b00;
  logic [W-1:0] cmd_arg = '0;
  logic         abort = 1'b0;
  logic         cmd_ready, busy, load_n, up_down, ce, done, resp_abort;
  logic [W-1:0] data_load, resp_count, count_out;
  logic         zero_flag, max_count;

  counter_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .abort(abort), .busy(busy),
    .load_n(load_n), .data_load(data_load), .up_down(up_down), .ce(ce),
    .count_out(count_out), .zero_flag(zero_flag), .max_count(max_count),
    .done(done), .resp_count(resp_count), .resp_abort(resp_abort)
  );

  always #5 clk = ~clk;

  // Counter datapath stand-in; it is not reset by rst_n
  logic [W-1:0] cnt = '0;
  always @(posedge clk) begin
    if (!load_n) cnt <= data_load;
    else if (ce) cnt <= up_down ? cnt + W'(1) : cnt - W'(1);
  end
  assign count_out = cnt;
  assign zero_flag = (cnt == '0);
  assign max_count = (cnt == '1);

  typedef struct {
    bit busy;
    bit ce;
    bit ldn;
    bit done;
    bit ud;
    int dl;
    int rc;
    bit ra;
  } exp_t;

  exp_t q[$];
  int m_cnt = 0;
  int m_rc = 0;
  int m_ra = 0;
  int errors = 0;
  int checks = 0;
  int ce_cnt = 0;

  always @(posedge clk) if (rst_n && ce) ce_cnt <= ce_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(bit b, bit c, bit l, bit d, bit u, int dl, int rc, bit ra);
    exp_t e;
    e.busy = b; e.ce = c; e.ldn = l; e.done = d; e.ud = u; e.dl = dl; e.rc = rc; e.ra = ra;
    return e;
  endfunction

  // Per-cycle compare against the predicted trace (idle when nothing is pending)
  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (q.size() > 0) e = q.pop_front();
    else e = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, m_rc, m_ra[0]);
    chk("busy", 32'(busy), 32'(e.busy));
    chk("cmd_ready", 32'(cmd_ready), 32'(!e.busy));
    chk("ce", 32'(ce), 32'(e.ce));
    chk("load_n", 32'(load_n), 32'(e.ldn));
    chk("done", 32'(done), 32'(e.done));
    chk("resp_count", 32'(resp_count), 32'(e.rc));
    chk("resp_abort", 32'(resp_abort), 32'(e.ra));
    if (e.ce) chk("up_down", 32'(up_down), 32'(e.ud));
    if (!e.ldn) chk("data_load", 32'(data_load), 32'(e.dl));
  end

  // Issue one command, predict its whole trace, and drive abort on busy cycle ab_at
  task automatic do_cmd(input int op, input int arg, input int ab_at);
    int  steps, extra, len, old_rc, old_ra;
    bit  up, aborted;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'(op);
    cmd_arg   = W'(arg);
    @(posedge clk);
    old_rc = m_rc;
    old_ra = m_ra;
    steps = 0; extra = 0; aborted = 1'b0; up = 1'b0; len = 0;
    if (op == 0) begin
      q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, arg, old_rc, old_ra[0]));
      len++;
      m_cnt = arg;
    end else begin
      if (op == 3) begin
        up    = (arg % 2) == 1;
        steps = up ? (MAXV - m_cnt) : m_cnt;
        extra = 1;
        if (ab_at >= 1 && ab_at <= steps) begin
          steps = ab_at - 1;
          aborted = 1'b1;
        end
      end else begin
        up    = (op == 1);
        steps = arg;
        if (ab_at >= 1 && ab_at <= arg) begin
          steps = ab_at - 1;
          extra = 1;
          aborted = 1'b1;
        end
      end
      for (int i = 0; i < steps; i++) begin
        q.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, up, 0, old_rc, old_ra[0]));
        len++;
      end
      for (int i = 0; i < extra; i++) begin
        q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, up, 0, old_rc, old_ra[0]));
        len++;
      end
      m_cnt = up ? (m_cnt + steps) % MODV : (((m_cnt - steps) % MODV) + MODV) % MODV;
    end
    q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, old_rc, old_ra[0]));
    q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, m_cnt, aborted));
    len += 2;
    m_rc = m_cnt;
    m_ra = aborted ? 1 : 0;
    #1 cmd_valid = 1'b0;
    for (int i = 1; i <= len; i++) begin
      @(negedge clk);
      abort = (i == ab_at);
    end
    abort = 1'b0;
  endtask

  initial begin
    int c0;
    #7;
    chk("rst_up_down", 32'(up_down), 32'd0);
    chk("rst_data_load", 32'(data_load), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_cmd(0, 9, 0);
    chk("lit_load9", 32'(resp_count), 32'd9);
    chk("lit_load9_ab", 32'(resp_abort), 32'd0);

    do_cmd(0, 14, 0);
    c0 = ce_cnt;
    do_cmd(1, 3, 0);
    chk("lit_up_wrap", 32'(resp_count), 32'd1);
    chk("lit_up_wrap_ce", 32'(ce_cnt - c0), 32'd3);

    c0 = ce_cnt;
    do_cmd(2, 0, 0);
    chk("lit_down0", 32'(resp_count), 32'd1);
    chk("lit_down0_ce", 32'(ce_cnt - c0), 32'd0);

    do_cmd(0, 5, 0);
    do_cmd(2, 2, 0);
    chk("lit_down2", 32'(resp_count), 32'd3);

    do_cmd(0, 12, 0);
    c0 = ce_cnt;
    do_cmd(3, 1, 0);
    chk("lit_run_up", 32'(resp_count), 32'd15);
    chk("lit_run_up_ce", 32'(ce_cnt - c0), 32'd3);

    do_cmd(0, 0, 0);
    c0 = ce_cnt;
    do_cmd(3, 0, 0);
    chk("lit_run_dn0", 32'(resp_count), 32'd0);
    chk("lit_run_dn0_ce", 32'(ce_cnt - c0), 32'd0);

    c0 = ce_cnt;
    do_cmd(1, 10, 4);
    chk("lit_abort_step", 32'(resp_count), 32'd3);
    chk("lit_abort_step_ab", 32'(resp_abort), 32'd1);
    chk("lit_abort_step_ce", 32'(ce_cnt - c0), 32'd3);

    do_cmd(0, 13, 0);
    do_cmd(3, 1, 3);
    chk("lit_run_lim_abort", 32'(resp_count), 32'd15);
    chk("lit_run_lim_abort_ab", 32'(resp_abort), 32'd0);

    do_cmd(0, 2, 0);
    do_cmd(3, 0, 1);
    chk("lit_run_abort", 32'(resp_count), 32'd2);
    chk("lit_run_abort_ab", 32'(resp_abort), 32'd1);

    // Reset in the middle of STEP_UP 8 after three counting cycles
    c0 = ce_cnt;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_arg   = W'(8);
    @(posedge clk);
    for (int i = 0; i < 3; i++) q.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0, m_rc, m_ra[0]));
    #1 cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    m_rc  = 0;
    m_ra  = 0;
    m_cnt = (m_cnt + 3) % MODV;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("lit_rst_ce", 32'(ce_cnt - c0), 32'd3);
    chk("lit_rst_resp", 32'(resp_count), 32'd0);
    repeat (2) @(negedge clk);

    do_cmd(2, 0, 0);
    chk("lit_rst_kept", 32'(resp_count), 32'd5);
    do_cmd(0, 2, 0);
    chk("lit_rst_load2", 32'(resp_count), 32'd2);
    repeat (3) @(negedge clk);

    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
